data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
- Parametrised, byte-addressed data memory with a RISC-V load/store front end. Supports LB/LH/LW/LBU/LHU/SB/SH/SW.
- Uses per-byte write enables, load sign/zero extension, and misaligned/out-of-range/illegal-op error detection.
- Has a valid/ready request channel, a valid/ready response channel and configurable access latency.
- Sits in the MEM stage of the pipeline. The pipeline stalls on `req_ready`/`resp_valid`.

Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words. Must be a power of 2 and ≥ 4.
- `LATENCY`, 1: cycles from request acceptance to `resp_valid`. Range 1..15.
- `ADDR_W`, 32: width of the byte address port.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; the low byte/half is used for SB/SH.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected; no memory side effect.
- `busy`  out  1  high in any state other than IDLE.

Behaviour:
- **Reset values.** `reset` forces state=IDLE, latency counter=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0 and `req_ready`=1 (IDLE). Memory array contents are not reset.
- **FSM states.** IDLE, WAIT, RESP.
  - **IDLE:** `req_ready`=1. When `req_valid` is high, capture `req_we`, `req_funct3`, `req_addr` and `req_wdata` at the edge, load counter=LATENCY-1, and go to WAIT.
  - **WAIT:** `req_ready`=0. While counter≠0, decrement. At the edge where counter==0, perform the access, register the response, and go to RESP. `resp_valid` therefore rises exactly LATENCY cycles after the accepting edge.
  - **RESP:** `resp_valid`=1, with `resp_rdata`/`resp_err` held stable until `resp_ready` is high at an edge; then go to IDLE. There is no new acceptance in RESP, so at most one request is outstanding.
- **Address decode.**
  - Word index = `req_addr[log2(DEPTH_WORDS)+1:2]`; lane = `req_addr[1:0]`.
  - Out of range if any bit of `req_addr` above `log2(DEPTH_WORDS)+1` is set.
- **Error conditions**, evaluated on captured fields:
  - Misaligned: H/HU with lane[0]=1, or W with lane≠0.
  - Out of range (as defined above).
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - On error: `resp_err`=1, `resp_rdata`=0, no memory write.
- **Stores.**
  - Byte enables: SB → one lane; SH → lanes {lane+1, lane}; SW → all four.
  - Store data is replicated into the enabled lanes (`wdata[7:0]` for SB, `wdata[15:0]` for SH).
  - Bytes not enabled keep their value.
  - Response: `resp_err`=0, `resp_rdata`=0.
- **Loads.**
  - The selected byte/half is taken from the addressed word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- **Store then load.** A load accepted after a store's response has completed sees the stored data.
- **Reset mid-operation.** Asserting `reset` in WAIT aborts the request with no write. Asserting it in RESP discards the response. Both return to IDLE.
- **Ignored inputs.** `req_valid` outside IDLE is ignored. The request source must hold its request until `req_ready`.
- **Simultaneous events.** `resp_ready` with `resp_valid`=0 has no effect. In RESP with `resp_ready`=1 and `req_valid`=1, the request is accepted on the following IDLE cycle, not the same edge.

Test Plan:
1. Reset, then SW addr 0x10, data 0xDEADBEEF; then LW 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` exactly LATENCY cycles after each accept (run with LATENCY=1 and 3).
2. SW 0x20 = 0x00000000; SB 0x22 wdata 0x000000F0 → LW 0x20 = 0x00F00000. LB 0x22 = 0xFFFFFFF0; LBU 0x22 = 0x000000F0.
3. SH 0x30 wdata 0x00008001 → LH 0x30 = 0xFFFF8001; LHU 0x30 = 0x00008001. SH 0x31 → `resp_err`=1 and LW 0x30 unchanged.
4. LW 0x1002 (misaligned) and LW 0x00001000 (out of range for 1024 words) → `resp_err`=1, `resp_rdata`=0. Load funct3=011 → `resp_err`=1.
5. Hold `resp_ready`=0 for 5 cycles after LW → `resp_valid`/`resp_rdata` stable and `req_ready`=0 throughout; release → IDLE next cycle, `req_ready`=1.
6. SW 0x40 = 0x11111111 completes; then SW 0x40 = 0x22222222 with `reset` asserted during WAIT (LATENCY=3) → outputs return to reset values; LW 0x40 returns 0x11111111.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with a RISC-V load/store front end.
// One outstanding request; valid/ready on both request and response channels.
module data_memory_lsu #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          out_of_range, misaligned, illegal, err;
   logic [3:0]    be;
   logic [31:0]   wdata_rep, rd_word, load_data;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic          do_access;

   always_comb begin
      word_idx     = addr_q[AW+1:2];
      lane         = addr_q[1:0];
      out_of_range = (addr_q >> (AW + 2)) != '0;
      misaligned   = (funct3_q[1:0] == 2'b01 && lane[0]) ||
                     (funct3_q[1:0] == 2'b10 && lane != 2'b00);
      illegal      = we_q ? (funct3_q > 3'b010)
                          : (funct3_q == 3'b011 || funct3_q[2:1] == 2'b11);
      err          = out_of_range || misaligned || illegal;

      be        = 4'b0000;
      wdata_rep = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be        = 4'b0011 << lane;
            wdata_rep = {2{wdata_q[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase

      rd_word = mem[word_idx];
      ld_byte = rd_word[{lane, 3'b000} +: 8];
      ld_half = rd_word[{lane[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, ld_byte};
         3'b101:  load_data = {16'd0, ld_half};
         default: load_data = 32'd0;
      endcase

      do_access = (state == StWait) && (cnt == 4'd0);
   end

   // Array is deliberately left out of reset; an aborted WAIT never reaches do_access.
   always_ff @(posedge clk) begin
      if (do_access && we_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         funct3_q   <= 3'd0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  funct3_q  <= req_funct3;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  cnt       <= 4'(LATENCY - 1);
                  state     <= StWait;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            StWait: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state      <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= err;
                  resp_rdata <= (err || we_q) ? 32'd0 : load_data;
               end
            end
            StResp: begin
               if (resp_ready) begin
                  state      <= StIdle;
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: directed loads/stores, errors, stalls, reset abort.
module tb_data_memory_lsu;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err, busy;
   logic [31:0] resp_rdata;

   data_memory_lsu #(
      .DEPTH_WORDS(1024),
      .LATENCY    (LAT),
      .ADDR_W     (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic prev_valid = 1'b0;
   int   lat_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: latency measured on rise of resp_valid, data compared on handshake.
   always @(negedge clk) begin
      if (!reset) begin
         if (resp_valid && !prev_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
               lat_acc = q[0].acc;
               chk("latency", 32'(cyc - lat_acc), 32'(LAT));
            end
         end
         if (resp_valid && resp_ready && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rd);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
         end
      end
      prev_valid = resp_valid && !reset;
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input bit track);
      int n = 0;
      @(posedge clk); #1;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
         end
      end
      if (track) q.push_back('{rd: exp_rd, err: exp_err, acc: cyc + 1});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input logic e);
      issue(1'b1, f3, a, d, 32'd0, e, 1'b1);
   endtask

   task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r,
                     input logic e);
      issue(1'b0, f3, a, 32'd0, r, e, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !req_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1 reset = 1'b0;

      // Word store/load
      st(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      ld(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

      // Byte lanes and extension
      st(3'b010, 32'h20, 32'h0, 1'b0);
      st(3'b000, 32'h22, 32'h000000F0, 1'b0);
      ld(3'b010, 32'h20, 32'h00F00000, 1'b0);
      ld(3'b000, 32'h22, 32'hFFFFFFF0, 1'b0);
      ld(3'b100, 32'h22, 32'h000000F0, 1'b0);

      // Halfword lanes, misaligned store has no side effect
      st(3'b010, 32'h30, 32'h0, 1'b0);
      st(3'b001, 32'h30, 32'h00008001, 1'b0);
      ld(3'b001, 32'h30, 32'hFFFF8001, 1'b0);
      ld(3'b101, 32'h30, 32'h00008001, 1'b0);
      st(3'b001, 32'h31, 32'h00001234, 1'b1);
      ld(3'b010, 32'h30, 32'h00008001, 1'b0);
      st(3'b001, 32'h32, 32'h0000ABCD, 1'b0);
      ld(3'b010, 32'h30, 32'hABCD8001, 1'b0);
      ld(3'b101, 32'h32, 32'h0000ABCD, 1'b0);

      // Errors and boundary word
      ld(3'b010, 32'h1002, 32'h0, 1'b1);
      ld(3'b010, 32'h1000, 32'h0, 1'b1);
      ld(3'b011, 32'h10, 32'h0, 1'b1);
      ld(3'b110, 32'h10, 32'h0, 1'b1);
      ld(3'b001, 32'h11, 32'h0, 1'b1);
      st(3'b100, 32'h10, 32'h0, 1'b1);
      st(3'b010, 32'h12, 32'h0, 1'b1);
      ld(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      st(3'b010, 32'hFFC, 32'hCAFEF00D, 1'b0);
      ld(3'b000, 32'hFFF, 32'hFFFFFFCA, 1'b0);
      ld(3'b010, 32'hFFC, 32'hCAFEF00D, 1'b0);
      drain();

      // Response back-pressure
      resp_ready = 1'b0;
      ld(3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_resp_rdata", resp_rdata, 32'hDEADBEEF);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_req_ready", {31'd0, req_ready}, 32'd1);
      chk("release_busy", {31'd0, busy}, 32'd0);

      // Reset during WAIT aborts the store
      st(3'b010, 32'h40, 32'h11111111, 1'b0);
      drain();
      issue(1'b1, 3'b010, 32'h40, 32'h22222222, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("abort");
      @(posedge clk); #1 reset = 1'b0;
      ld(3'b010, 32'h40, 32'h11111111, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
